scan_loader: RTL and testbench

Scan-chain master that drives the `scan_enable`/`scan_in` pins of the memory bank and collects its `scan_out` stream. Bytes arrive on a valid/ready input stream and are shifted serially into the chain. The bits leaving the far end are reassembled into bytes on a valid/ready output stream. The block sits between the host/programming interface and the memory bank: it loads programs and reads back the previous chain contents (memory cells, button and LED registers) in the same pass.

---
 rtl/scan_loader_if.sv | 23 ++
 rtl/scan_loader.sv | 106 ++++++++++
 tb/tb_scan_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_loader_if.sv
// Byte streams and scan-chain pins between the scan loader and its neighbours.
// master = the loader; slave = host streams plus the chain's far end.
interface scan_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;

  modport master (
    input  in_data, in_valid, out_ready, scan_out,
    output in_ready, out_data, out_valid, scan_enable, scan_in
  );

  modport slave (
    output in_data, in_valid, out_ready, scan_out,
    input  in_ready, out_data, out_valid, scan_enable, scan_in
  );
endinterface

// File: rtl/scan_loader.sv
// Scan-chain master: shifts input bytes MSB-first into the memory bank chain and
// reassembles the bits leaving the far end into readback bytes in the same pass.
module scan_loader #(
  parameter int unsigned NUM_BYTES = 32,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  scan_loader_if.master bus_io,
  output logic          busy,
  output logic          done
);

  localparam logic [CNT_WIDTH-1:0] LastByte = CNT_WIDTH'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StEmit  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           sreg_q, sreg_d;
  logic [7:0]           cap_q, cap_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [CNT_WIDTH-1:0] bytecnt_q, bytecnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      sreg_q    <= 8'h00;
      cap_q     <= 8'h00;
      bitcnt_q  <= 3'd0;
      bytecnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cap_q     <= cap_d;
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cap_d     = cap_q;
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          bytecnt_d = '0;
        end
      end
      StLoad: begin
        if (bus_io.in_valid) begin
          sreg_d   = bus_io.in_data;
          bitcnt_d = 3'd0;
          state_d  = StShift;
        end
      end
      StShift: begin
        // scan_out is captured at the same edge that moves the chain: pre-shift value.
        sreg_d   = {sreg_q[6:0], 1'b0};
        cap_d    = {cap_q[6:0], bus_io.scan_out};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus_io.out_ready) begin
          if (bytecnt_q == LastByte) begin
            state_d = StDone;
          end else begin
            bytecnt_d = bytecnt_q + 1'b1;
            state_d   = StLoad;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    bus_io.in_ready    = (state_q == StLoad);
    bus_io.scan_enable = (state_q == StShift);
    bus_io.scan_in     = (state_q == StShift) && sreg_q[7];
    bus_io.out_valid   = (state_q == StEmit);
    bus_io.out_data    = cap_q;
    busy               = (state_q != StIdle);
    done               = (state_q == StDone);
  end

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader: per-cycle vector table plus full-pass sequences
// against a 256-bit behavioural model of the memory bank scan chain.
module tb_scan_loader;
  localparam int unsigned NB = 32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  scan_loader_if lif ();

  scan_loader #(
    .NUM_BYTES(NB),
    .CNT_WIDTH(5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus_io(lif),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Chain model: bit 255 is the scan_out end.
  logic [255:0] chain = {8'hC3, 248'h0};
  always @(posedge clk) begin
    if (lif.scan_enable === 1'b1) chain <= {chain[254:0], lif.scan_in};
  end
  assign lif.scan_out = chain[255];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // exp bits: {in_ready, busy, scan_enable, scan_in, out_valid, done}
  typedef struct {
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic [5:0] exp;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[17];

  logic [7:0] tx[NB];
  logic [7:0] rx[NB];
  int n_rx, n_shift, n_done, done_cyc;
  int in_stall_byte, in_stall_n, out_stall_byte, out_stall_n;
  int start_abuse_cyc, rst_byte, rst_shift;

  task automatic clear_cfg();
    in_stall_byte   = -1;
    in_stall_n      = 0;
    out_stall_byte  = -1;
    out_stall_n     = 0;
    start_abuse_cyc = 0;
    rst_byte        = -1;
    rst_shift       = 0;
  endtask

  // One pass; the cycle in which start is driven is cycle 1.
  task automatic run_pass(input string tag);
    int cyc, acc, byte_shift, in_left, out_left;
    logic [7:0] held;
    bit fin, did_rst;
    n_rx = 0; n_shift = 0; n_done = 0; done_cyc = 0;
    acc = 0; byte_shift = 0; fin = 0; did_rst = 0; held = 8'h00;
    in_left = in_stall_n;
    out_left = out_stall_n;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; lif.in_valid = 1'b0; lif.out_ready = 1'b1;
    cyc = 1;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == start_abuse_cyc);
      rst = 1'b1;
      if (did_rst) begin
        chk({tag, " post_rst_se"}, 32'(lif.scan_enable), 32'd0);
        chk({tag, " post_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, " post_rst_ovalid"}, 32'(lif.out_valid), 32'd0);
        fin = 1;
      end else begin
        if (done) begin
          n_done++;
          done_cyc = cyc;
          fin = 1;
        end
        if (lif.scan_enable) begin
          n_shift++;
          byte_shift++;
        end
        if (acc == in_stall_byte && in_left > 0 && (lif.in_ready || in_left < in_stall_n)) begin
          chk({tag, " in_stall_ready"}, 32'(lif.in_ready), 32'd1);
          chk({tag, " in_stall_se"}, 32'(lif.scan_enable), 32'd0);
          lif.in_valid = 1'b0;
          in_left--;
        end else if (lif.in_ready && acc < int'(NB)) begin
          lif.in_valid = 1'b1;
          lif.in_data  = tx[acc];
          acc++;
          byte_shift = 0;
        end else begin
          lif.in_valid = 1'b0;
        end
        if (lif.out_valid) begin
          if (n_rx == out_stall_byte && out_left > 0) begin
            if (out_left == out_stall_n) held = lif.out_data;
            else chk({tag, " out_stall_data"}, 32'(lif.out_data), 32'(held));
            chk({tag, " out_stall_se"}, 32'(lif.scan_enable), 32'd0);
            lif.out_ready = 1'b0;
            out_left--;
          end else begin
            lif.out_ready = 1'b1;
            if (n_rx < int'(NB)) rx[n_rx] = lif.out_data;
            n_rx++;
          end
        end else begin
          lif.out_ready = 1'b1;
        end
        if (acc == rst_byte + 1 && lif.scan_enable && byte_shift == rst_shift) begin
          rst = 1'b0;
          did_rst = 1;
        end
      end
    end
    chk({tag, " pass_finished"}, 32'(fin), 32'd1);
    start = 1'b0;
    lif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, " done_once"}, 32'(done), 32'd0);
    chk({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    lif.in_valid = 1'b0; lif.in_data = 8'h00; lif.out_ready = 1'b0;

    // in_data 0xB4 goes out MSB first: 1,0,1,1,0,1,0,0.
    vt[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'b000000, 1'b1, 8'h00};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'b000000, 1'b1, 8'h00};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b000000, 1'b1, 8'h00};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 6'b110000, 1'b1, 8'h00};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b110000, 1'b1, 8'h00};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 8'hB4, 1'b0, 6'b011100, 1'b1, 8'h00};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b011000, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b011100, 1'b0, 8'h00};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b011100, 1'b0, 8'h00};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 6'b011000, 1'b0, 8'h00};
    vt[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b011100, 1'b0, 8'h00};
    vt[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b011000, 1'b0, 8'h00};
    vt[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b011000, 1'b0, 8'h00};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b010010, 1'b1, 8'hC3};
    vt[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b010010, 1'b1, 8'hC3};
    vt[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 6'b110000, 1'b1, 8'hC3};
    vt[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b000000, 1'b1, 8'h00};

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = vt[i].rst;
      start = vt[i].start;
      lif.in_valid = vt[i].in_valid;
      lif.in_data = vt[i].in_data;
      lif.out_ready = vt[i].out_ready;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d flags", i),
          32'({lif.in_ready, busy, lif.scan_enable, lif.scan_in, lif.out_valid, done}),
          32'(vt[i].exp));
      if (vt[i].chk_data) chk($sformatf("vec%0d out_data", i), 32'(lif.out_data),
                              32'(vt[i].exp_data));
    end

    // Pass 1: load 0x00..0x1F back-to-back.
    clear_cfg();
    for (int k = 0; k < int'(NB); k++) tx[k] = 8'(k);
    run_pass("p1");
    chk("p1 shifts", 32'(n_shift), 32'd256);
    chk("p1 done_cnt", 32'(n_done), 32'd1);
    chk("p1 done_cycle", 32'(done_cyc), 32'd322);
    chk("p1 rx_cnt", 32'(n_rx), 32'd32);
    for (int k = 0; k < int'(NB); k++) chk($sformatf("p1 cell%0d", k), 32'(chain[255-8*k -: 8]), 32'(k));

    // Pass 2: readback with 0xA5 fill, start pulsed mid-SHIFT.
    clear_cfg();
    start_abuse_cyc = 5;
    for (int k = 0; k < int'(NB); k++) tx[k] = 8'hA5;
    run_pass("p2");
    chk("p2 shifts", 32'(n_shift), 32'd256);
    chk("p2 done_cnt", 32'(n_done), 32'd1);
    chk("p2 rx_cnt", 32'(n_rx), 32'd32);
    for (int k = 0; k < int'(NB); k++) chk($sformatf("p2 rx%0d", k), 32'(rx[k]), 32'(k));

    // Pass 3: output backpressure on byte 3, input stall on byte 5.
    clear_cfg();
    out_stall_byte = 3; out_stall_n = 5;
    in_stall_byte = 5; in_stall_n = 7;
    for (int k = 0; k < int'(NB); k++) tx[k] = 8'(8'h40 + k);
    run_pass("p3");
    chk("p3 shifts", 32'(n_shift), 32'd256);
    chk("p3 done_cnt", 32'(n_done), 32'd1);
    chk("p3 rx_cnt", 32'(n_rx), 32'd32);
    for (int k = 0; k < int'(NB); k++) chk($sformatf("p3 rx%0d", k), 32'(rx[k]), 32'h0A5);
    for (int k = 0; k < int'(NB); k++)
      chk($sformatf("p3 cell%0d", k), 32'(chain[255-8*k -: 8]), 32'(8'h40 + k));

    // Pass 4: reset on the 4th SHIFT cycle of byte 10.
    clear_cfg();
    rst_byte = 10; rst_shift = 4;
    for (int k = 0; k < int'(NB); k++) tx[k] = 8'(k) ^ 8'hFF;
    run_pass("p4");
    chk("p4 shifts", 32'(n_shift), 32'd84);
    chk("p4 done_cnt", 32'(n_done), 32'd0);
    chk("p4 rx_cnt", 32'(n_rx), 32'd10);
    for (int k = 0; k < 10; k++) chk($sformatf("p4 rx%0d", k), 32'(rx[k]), 32'(8'h40 + k));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p4 quiet_done", 32'(done), 32'd0);
      chk("p4 quiet_se", 32'(lif.scan_enable), 32'd0);
    end
    chk("p4 out_data_cleared", 32'(lif.out_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
